// File: rtl/fixed_mul_pkg.sv
// fixed_mul_pkg
//   Shared definitions for the pipelined fixed-point multiplier:
//   mode encodings, per-stage control payloads and saturation limits.
package fixed_mul_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Control captured with the operands in S1. The sign is already forced
    // to 0 when either operand is zero.
    typedef struct packed {
        logic mode;
        logic rnd;
        logic sign;
        logic zero;
    } s1_ctl_t;

    // Control still needed by S3 after the product is formed.
    typedef struct packed {
        logic rnd;
        logic sign;
    } s2_ctl_t;

    // Largest magnitude representable as a positive w-bit result.
    function automatic longint unsigned sat_pos_lim(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Largest magnitude representable as a negative w-bit result.
    function automatic longint unsigned sat_neg_lim(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fixed_mul_lod.sv
// fixed_mul_lod
//   Priority leading-one detector.
//   i_val  : unsigned magnitude
//   o_pos  : bit index of the most significant one (0 when i_val is 0)
//   o_frac : bits below the leading one, left-aligned into WIDTH-1 bits
module fixed_mul_lod #(
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_val,
    output logic [PW-1:0]    o_pos,
    output logic [WIDTH-2:0] o_frac
);

    logic [PW-1:0] w_shamt;

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        o_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_val[i]) o_pos = PW'(i);
        end
    end

    // Shifting the leading one up to bit WIDTH-1 and dropping it leaves the
    // remaining bits MSB-aligned in the lower WIDTH-1 positions.
    assign w_shamt = PW'(WIDTH - 1) - o_pos;
    assign o_frac  = (WIDTH-1)'(i_val << w_shamt);

endmodule

// File: rtl/fixed_mul_pipe.sv
// fixed_mul_pipe
//   Three-stage signed fixed-point multiplier, exact or Mitchell-log
//   approximate product, with rounding and saturation.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake
//   in_a, in_b          : signed Q operands (DEC_POINT_POS fraction bits)
//   in_mode             : 0 exact, 1 approximate
//   in_round            : 0 truncate, 1 round half up on magnitude
//   in_mask             : fraction mask for approximate mode
//   out_valid/out_ready : result handshake
//   out_r, out_ovf      : signed Q result, saturation flag
//   out_valid rises on the third rising edge counting the accepting one.
module fixed_mul_pipe import fixed_mul_pkg::*; #(
    parameter int WIDTH         = 8,
    parameter int DEC_POINT_POS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_round,
    input  logic [WIDTH-2:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_ovf
);

    localparam int PW     = $clog2(WIDTH);
    localparam int STAGES = 3;
    localparam int PRW    = 2 * WIDTH;

    localparam logic [PRW:0] LIM_POS  = (PRW+1)'(sat_pos_lim(WIDTH));
    localparam logic [PRW:0] LIM_NEG  = (PRW+1)'(sat_neg_lim(WIDTH));
    localparam logic [PRW:0] RND_HALF = (PRW+1)'(1) << (DEC_POINT_POS - 1);

    typedef struct packed {
        logic [WIDTH-1:0] mag_a;
        logic [WIDTH-1:0] mag_b;
        logic [PW-1:0]    ka;
        logic [PW-1:0]    kb;
        logic [WIDTH-2:0] fa;
        logic [WIDTH-2:0] fb;
        s1_ctl_t          ctl;
    } s1_t;

    typedef struct packed {
        logic [PRW-1:0] prod;
        s2_ctl_t        ctl;
    } s2_t;

    logic              w_en;
    logic              w_accept;
    logic [STAGES:1]   r_vld_pipe;
    s1_t               r_s1, w_s1;
    s2_t               r_s2, w_s2;
    logic [WIDTH-1:0]  r_out_r, w_res;
    logic              r_out_ovf, w_ovf;

    logic [WIDTH-1:0]  w_mag_a, w_mag_b;
    logic [PW-1:0]     w_pos_a, w_pos_b;
    logic [WIDTH-2:0]  w_frac_a, w_frac_b;

    logic [PW:0]       w_ksum, w_shamt;
    logic [WIDTH-1:0]  w_fsum, w_base;
    logic [3*WIDTH-1:0] w_wide;

    logic [PRW:0]      w_sum, w_mag;

    // One global enable: the whole pipe moves unless a result is parked.
    assign w_en      = ~r_vld_pipe[STAGES] | out_ready;
    assign in_ready  = w_en & ~rst;
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_vld_pipe[STAGES];
    assign out_r     = r_out_r;
    assign out_ovf   = r_out_ovf;

    // ---------------- S1: magnitude, leading one, fraction ----------------
    // Unsigned negation of the most negative value yields 2^(WIDTH-1).
    assign w_mag_a = in_a[WIDTH-1] ? -in_a : in_a;
    assign w_mag_b = in_b[WIDTH-1] ? -in_b : in_b;

    fixed_mul_lod #(.WIDTH(WIDTH)) u_lod_a (
        .i_val  (w_mag_a),
        .o_pos  (w_pos_a),
        .o_frac (w_frac_a)
    );

    fixed_mul_lod #(.WIDTH(WIDTH)) u_lod_b (
        .i_val  (w_mag_b),
        .o_pos  (w_pos_b),
        .o_frac (w_frac_b)
    );

    always_comb begin
        w_s1          = '0;
        w_s1.mag_a    = w_mag_a;
        w_s1.mag_b    = w_mag_b;
        w_s1.ka       = w_pos_a;
        w_s1.kb       = w_pos_b;
        w_s1.fa       = w_frac_a & in_mask;
        w_s1.fb       = w_frac_b & in_mask;
        w_s1.ctl.mode = in_mode;
        w_s1.ctl.rnd  = in_round;
        w_s1.ctl.zero = (w_mag_a == '0) | (w_mag_b == '0);
        w_s1.ctl.sign = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & ~w_s1.ctl.zero;
    end

    // ---------------- S2: exact multiply or log-domain add ----------------
    always_comb begin
        w_s2          = '0;
        w_s2.ctl.rnd  = r_s1.ctl.rnd;
        w_s2.ctl.sign = r_s1.ctl.sign;

        w_ksum = {1'b0, r_s1.ka} + {1'b0, r_s1.kb};
        w_fsum = {1'b0, r_s1.fa} + {1'b0, r_s1.fb};
        // Fraction sum below 1: mantissa is 1+xa+xb. Otherwise the carry
        // becomes the implicit one and the exponent grows by one.
        if (w_fsum[WIDTH-1]) begin
            w_base  = w_fsum;
            w_shamt = w_ksum + 1'b1;
        end else begin
            w_base  = {1'b1, w_fsum[WIDTH-2:0]};
            w_shamt = w_ksum;
        end
        w_wide = {{PRW{1'b0}}, w_base} << w_shamt;

        if (r_s1.ctl.zero) begin
            w_s2.prod = '0;
        end else if (r_s1.ctl.mode == MODE_APPROX) begin
            // Drop the WIDTH-1 fraction bits of the log mantissa.
            w_s2.prod = PRW'(w_wide >> (WIDTH - 1));
        end else begin
            w_s2.prod = PRW'(r_s1.mag_a) * PRW'(r_s1.mag_b);
        end
    end

    // ---------------- S3: round, scale, saturate, sign ----------------
    always_comb begin
        w_sum = {1'b0, r_s2.prod} + (r_s2.ctl.rnd ? RND_HALF : '0);
        w_mag = w_sum >> DEC_POINT_POS;
        w_ovf = 1'b0;
        if (!r_s2.ctl.sign && (w_mag > LIM_POS)) begin
            w_res = {1'b0, {(WIDTH-1){1'b1}}};
            w_ovf = 1'b1;
        end else if (r_s2.ctl.sign && (w_mag > LIM_NEG)) begin
            w_res = {1'b1, {(WIDTH-1){1'b0}}};
            w_ovf = 1'b1;
        end else if (r_s2.ctl.sign) begin
            w_res = -w_mag[WIDTH-1:0];
        end else begin
            w_res = w_mag[WIDTH-1:0];
        end
    end

    // ---------------- Stage registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_out_r    <= '0;
            r_out_ovf  <= 1'b0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_accept};
            r_s1       <= w_s1;
            r_s2       <= w_s2;
            // Holes leave a zero result behind rather than stale data.
            r_out_r    <= r_vld_pipe[STAGES-1] ? w_res : '0;
            r_out_ovf  <= r_vld_pipe[STAGES-1] & w_ovf;
        end
    end

endmodule

// File: tb/tb_fixed_mul_pipe.sv
module tb_fixed_mul_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic       in_mode, in_round;
    logic [6:0] in_mask;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_r;
    logic       out_ovf;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [8:0] exp_q[$];     // {ovf, r}
    bit         bp_on  = 1'b0;
    logic       ready_force = 1'b1;

    fixed_mul_pipe #(.WIDTH(8), .DEC_POINT_POS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .in_round  (in_round),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Sole driver of out_ready: random when backpressure is on.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_on ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Reference model written straight from the arithmetic definition.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic mode, input logic rnd,
                                         input logic [6:0] mask);
        longint ma, mb, p, m, fa, fb, s;
        int     ka, kb;
        logic   neg;
        logic [7:0] r;
        ma = a[7] ? 256 - longint'(a) : longint'(a);
        mb = b[7] ? 256 - longint'(b) : longint'(b);
        if (ma == 0 || mb == 0) return 9'h000;
        neg = a[7] ^ b[7];
        if (!mode) begin
            p = ma * mb;
        end else begin
            ka = 0;
            while ((longint'(1) << (ka + 1)) <= ma) ka++;
            kb = 0;
            while ((longint'(1) << (kb + 1)) <= mb) kb++;
            fa = (((ma - (longint'(1) << ka)) << 7) >> ka) & longint'(mask);
            fb = (((mb - (longint'(1) << kb)) << 7) >> kb) & longint'(mask);
            s  = fa + fb;
            if (s < 128) p = ((128 + s) << (ka + kb)) >> 7;
            else         p = (s << (ka + kb + 1)) >> 7;
        end
        m = (p + (rnd ? 8 : 0)) >> 4;
        if (!neg && m > 127) return {1'b1, 8'h7F};
        if (neg && m > 128)  return {1'b1, 8'h80};
        r = neg ? 8'(-m) : 8'(m);
        return {1'b0, r};
    endfunction

    // Output monitor: scoreboard pop on transfer, hold check while stalled.
    initial begin
        logic [8:0] held;
        logic [8:0] e;
        bit         stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (stalled) begin
                    checks++;
                    if ({out_ovf, out_r} !== held) begin
                        errors++;
                        $display("FAIL stall_hold got=%h want=%h", {out_ovf, out_r}, held);
                    end
                end
                if (out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output got=%h want=none", {out_ovf, out_r});
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_ovf, out_r} !== e) begin
                            errors++;
                            $display("FAIL result got ovf=%b r=%h want ovf=%b r=%h",
                                     out_ovf, out_r, e[8], e[7:0]);
                        end
                    end
                    stalled = 1'b0;
                end else begin
                    held    = {out_ovf, out_r};
                    stalled = 1'b1;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic mode,
                        input logic rnd, input logic [6:0] mask, input logic [8:0] exp);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_mode = mode; in_round = rnd; in_mask = mask;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=in_ready0 want=in_ready1");
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Counts rising edges, including the accepting one, until out_valid.
    task automatic check_latency(input string name);
        int lat;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s got=%0d want=3", name, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        ready_force = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_ovf, out_r} !== 11'h000) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b ovf=%b r=%h want all 0",
                     in_ready, out_valid, out_ovf, out_r);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got=%b want=1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_exact_latency();
        send(8'h18, 8'h28, 1'b0, 1'b0, 7'h7F, {1'b0, 8'h3C});
        idle();
        check_latency("latency_exact");
        wait_drain();
    endtask

    task automatic test_approx();
        send(8'h18, 8'h28, 1'b1, 1'b0, 7'h7F, {1'b0, 8'h38});
        send(8'hE8, 8'h28, 1'b0, 1'b0, 7'h7F, {1'b0, 8'hC4});
        send(8'h18, 8'h28, 1'b1, 1'b0, 7'h00, {1'b0, 8'h20});
        idle();
        wait_drain();
    endtask

    task automatic test_round();
        send(8'h01, 8'h18, 1'b0, 1'b0, 7'h7F, {1'b0, 8'h01});
        send(8'h01, 8'h18, 1'b0, 1'b1, 7'h7F, {1'b0, 8'h02});
        send(8'hFF, 8'h18, 1'b0, 1'b1, 7'h7F, {1'b0, 8'hFE});
        idle();
        wait_drain();
    endtask

    task automatic test_saturation();
        send(8'h7F, 8'h7F, 1'b0, 1'b0, 7'h7F, {1'b1, 8'h7F});
        send(8'h80, 8'h80, 1'b0, 1'b0, 7'h7F, {1'b1, 8'h7F});
        send(8'h80, 8'h7F, 1'b0, 1'b0, 7'h7F, {1'b1, 8'h80});
        send(8'h00, 8'h80, 1'b0, 1'b0, 7'h7F, {1'b0, 8'h00});
        send(8'h00, 8'h80, 1'b1, 1'b1, 7'h7F, {1'b0, 8'h00});
        idle();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int start;
        logic [7:0] a, b;
        logic m, r;
        start = cyc;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            m = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            send(a, b, m, r, 7'h7F, model(a, b, m, r, 7'h7F));
        end
        idle();
        checks++;
        if (cyc - start != 6) begin
            errors++;
            $display("FAIL throughput got=%0d cycles want=6", cyc - start);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] a, b;
        logic [6:0] k;
        logic m, r;
        bp_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            m = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            k = 7'($urandom_range(0, 127));
            send(a, b, m, r, k, model(a, b, m, r, k));
        end
        idle();
        repeat (6) @(posedge clk);
        bp_on = 1'b0;
        ready_force = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        int seen;
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(8'h18, 8'h28, 1'b0, 1'b0, 7'h7F, {1'b0, 8'h3C});
        send(8'h7F, 8'h7F, 1'b0, 1'b0, 7'h7F, {1'b1, 8'h7F});
        send(8'hE8, 8'h28, 1'b0, 1'b0, 7'h7F, {1'b0, 8'hC4});
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        checks++;
        if ({out_valid, out_ovf, out_r} !== 10'h000) begin
            errors++;
            $display("FAIL midreset_clear got vld=%b ovf=%b r=%h want 0",
                     out_valid, out_ovf, out_r);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset got=%b want=0", in_ready);
        end
        rst = 1'b0;
        ready_force = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL stale_after_reset got=%0d want=0", seen);
        end
        @(posedge clk);
        #1;
        send(8'h18, 8'h28, 1'b1, 1'b0, 7'h7F, {1'b0, 8'h38});
        idle();
        check_latency("latency_after_reset");
        wait_drain();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0; in_b = '0; in_mode = 1'b0; in_round = 1'b0; in_mask = '1;
        test_reset();
        test_exact_latency();
        test_approx();
        test_round();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixed_mul_pipe.md
# fixed_mul_pipe

Pipelined, parametrised signed fixed-point multiplier with a run-time choice of exact or approximate (Mitchell-log) product, per-transaction precision mask, rounding and saturation. It sits between the datapath register file and the accumulation stage. It accepts one operand pair per cycle under a valid/ready handshake and returns a WIDTH-bit result in the same Q format as the operands.

## Interface
- WIDTH, 8: operand/result width, two's complement, ≥4.
- DEC_POINT_POS, 4: fractional bits of operands and result, 1..WIDTH-2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block accepts; transfer when in_valid & in_ready.
- in_a, in_b  in  WIDTH  signed operands.
- in_mode  in  1  0 = exact, 1 = approximate.
- in_round  in  1  0 = truncate, 1 = round-half-up on magnitude.
- in_mask  in  WIDTH-1  fraction-bit mask for approximate mode, MSB-aligned.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- out_r  out  WIDTH  signed result.
- out_ovf  out  1  result was saturated.

## Operation
- Magnitudes: |a|, |b| as WIDTH-bit unsigned; -2^(WIDTH-1) gives 2^(WIDTH-1) exactly. sign = a[MSB]^b[MSB].
- Either magnitude zero: P = 0, sign forced 0, ovf 0.
- Exact mode: P = |a|*|b|, 2*WIDTH bits.
- Approximate mode: k = leading-one position; fraction f = bits below leading one, left-aligned into WIDTH-1 bits, ANDed with in_mask; x = f/2^(WIDTH-1). If xa+xb < 1: P = 2^(ka+kb)*(1+xa+xb); else P = 2^(ka+kb+1)*(xa+xb). Fractional part of P truncated.
- Scale: M = (P + in_round*2^(DEC_POINT_POS-1)) >> DEC_POINT_POS.
- Saturate: positive and M > 2^(WIDTH-1)-1 → out_r = max positive, ovf 1; negative and M > 2^(WIDTH-1) → out_r = min negative, ovf 1; else out_r = sign ? -M : M.
- in_mode, in_round, in_mask captured with the operands and travel with the transaction; changes affect only later transactions.

## Timing
- Three stages: S1 magnitude + leading-one detect + fraction extract; S2 exact multiply or log-add; S3 round, saturate, sign, output register.
- Latency 3 cycles from accepting edge to out_valid, no bubbles when out_ready held high; throughput 1/cycle.
- Global advance en = ~out_valid | out_ready; all stages shift together when en; in_ready = en & ~rst.
- Stall: out_valid with out_ready low freezes every stage; out_r/out_ovf stable until transfer.
- Simultaneous accept and emit in one cycle is legal and is the steady state.
- Bubbles: a stage with valid 0 carries no data; holes propagate, out_valid 0 for them.
- Reset (any cycle, including mid-stall): all stage valids, out_valid, out_r, out_ovf cleared to 0 on the next edge; in-flight transactions discarded; in_ready 0 while rst high, 1 the cycle after.

## Structure
- Package fixed_mul_pkg: mode constants (MODE_EXACT, MODE_APPROX), stage payload struct typedefs, helper functions for saturation limits.
- Sub-module fixed_mul_lod: parametrised priority leading-one detector returning position and left-aligned fraction; instantiated twice in S1.
- Stage registers and handshake logic stay in fixed_mul_pipe.

## Test plan
- WIDTH 8, DEC 4, exact: a=0x18 (1.5), b=0x28 (2.5), truncate → out_r=0x3C (3.75), ovf 0, out_valid exactly 3 cycles after accept.
- Approximate, mask all ones: same operands → P=896, out_r=0x38; a=0xE8, b=0x28 exact → 0xC4.
- Rounding: a=0x01, b=0x18 exact: truncate → 0x01, round → 0x02.
- Saturation: 0x7F×0x7F exact → 0x7F ovf 1; 0x80×0x80 → 0x7F ovf 1; 0x80×0x7F → 0x80 ovf 1; 0x00×0x80 → 0x00 ovf 0.
- Backpressure: stream 10 random pairs with out_ready toggled pseudo-randomly → results in order, none lost or duplicated, out_r stable while stalled, matches reference model.
- Reset mid-stream: assert rst for 1 cycle with 3 transactions in flight → out_valid 0 next edge, no stale result emerges, next accepted pair returns correctly after 3 cycles.
